// File: rtl/timer_tc_pkg.sv
// Shared definitions for the countdown timer: register offsets, CTRL fields, modes, states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package timer_pkg;

  // Word offsets within the device (byte address bits [3:2])
  typedef logic [1:0] addr_t;

  localparam addr_t ADDR_CTRL   = 2'd0;
  localparam addr_t ADDR_PRESET = 2'd1;
  localparam addr_t ADDR_COUNT  = 2'd2;

  // CTRL field positions
  localparam int EN_BIT  = 0;
  localparam int MODE_LO = 1;
  localparam int MODE_HI = 2;
  localparam int IM_BIT  = 3;

  // Mode codes; the two reserved codes fall back to one-shot behaviour
  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  // Countdown sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  // CTRL as seen on the read bus: only the low nibble exists
  function automatic logic [31:0] ctrl_word(input logic [3:0] c);
    return {28'h0, c};
  endfunction

endpackage

// File: rtl/timer_tc_if.sv
// CPU-side register access port of the timer plus its interrupt line.
// Latency: reads are combinational, writes take effect at the sampling clock edge.
// Backpressure: none; every access completes in the cycle it is presented.
interface timer_tc_if;
  import timer_pkg::*;

  addr_t       addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (output addr, we, din, input dout, irq);
  modport slave  (input addr, we, din, output dout, irq);

endinterface

// File: rtl/timer_tc.sv
// Memory-mapped countdown timer (one-shot / periodic) driving one CP0 hardware interrupt.
// Latency: En written at edge E0 with PRESET=P raises the interrupt flag at edge E0+P+3.
// Backpressure: none; register writes always complete in the write cycle.
module timer_tc
  import timer_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0
) (
  input  logic      clk,
  input  logic      reset,
  timer_tc_if.slave bus
);

  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic        ctrl_wr;
  logic        preset_wr;
  logic [1:0]  mode;
  logic        unused_din_hi;

  assign ctrl_wr   = bus.we && (bus.addr == ADDR_CTRL);
  assign preset_wr = bus.we && (bus.addr == ADDR_PRESET);
  assign mode      = ctrl[MODE_HI:MODE_LO];

  // CTRL only stores its low nibble; the upper write bits are dropped on purpose
  assign unused_din_hi = &{1'b0, bus.din[31:4]};

  // Register file, countdown sequencer and interrupt flag advance together on each edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ctrl     <= 4'h0;
      preset   <= PRESET_RST;
      count    <= 32'h0;
      irq_flag <= 1'b0;
    end else begin
      // PRESET is only sampled at LOAD, so a write here never disturbs a running count
      if (preset_wr) begin
        preset <= bus.din;
      end

      case (state)
        S_IDLE: begin
          if (ctrl[EN_BIT]) begin
            state <= S_LOAD;
          end
        end

        S_LOAD: begin
          // Old PRESET wins if it is being written in this same cycle
          count <= preset;
          state <= S_CNT;
        end

        S_CNT: begin
          // Disable is checked first so COUNT freezes; zero before decrement so it never wraps
          if (!ctrl[EN_BIT]) begin
            state <= S_IDLE;
          end else if (count == 32'h0) begin
            irq_flag <= 1'b1;
            state    <= S_INT;
          end else begin
            count <= count - 32'd1;
          end
        end

        S_INT: begin
          if (mode == MODE_PERIODIC) begin
            // Periodic: one-cycle pulse, then reload if still enabled
            irq_flag <= 1'b0;
            state    <= ctrl[EN_BIT] ? S_LOAD : S_IDLE;
          end else begin
            // One-shot (and reserved modes): self-disable, flag held until acknowledged
            ctrl[EN_BIT] <= 1'b0;
            state        <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase

      // A CTRL write is the acknowledge and overrides the sequencer's own En clear
      if (ctrl_wr) begin
        ctrl     <= bus.din[3:0];
        irq_flag <= 1'b0;
      end
    end
  end

  // Combinational read mux; the reserved offset reads as zero
  always_comb begin
    bus.dout = 32'h0;
    case (bus.addr)
      ADDR_CTRL:   bus.dout = ctrl_word(ctrl);
      ADDR_PRESET: bus.dout = preset;
      ADDR_COUNT:  bus.dout = count;
      default:     bus.dout = 32'h0;
    endcase
  end

  // Device-level mask; the flag itself survives while masked
  assign bus.irq = irq_flag & ctrl[IM_BIT];

endmodule

// File: tb/tb_timer_tc.sv
// Directed and randomized checks of the countdown timer against a timing-rule model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_timer_tc;
  import timer_pkg::*;

  localparam logic [31:0] TB_PRESET_RST = 32'h0000_1234;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  timer_tc_if bus ();

  timer_tc #(.PRESET_RST(TB_PRESET_RST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (timing rules, cycle k after the En write edge) ----------
  // COUNT is visible as P at k=2, reaches 0 at k=P+2, flag rises at k=P+3,
  // periodic runs repeat with period P+3.
  function automatic logic [31:0] exp_count(input int p, input int k, input bit per);
    int j;
    if (k < 2) return 32'h0;
    if (!per && k >= p + 3) return 32'h0;
    j = k % (p + 3);
    if (j < 2) return 32'h0;
    return 32'(p - (j - 2));
  endfunction

  function automatic logic exp_flag(input int p, input int k, input bit per);
    if (k < p + 3) return 1'b0;
    if (!per) return 1'b1;
    return (k % (p + 3)) == 0;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rst();
    bus.we = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.din  = d;
    bus.we   = 1'b1;
    @(negedge clk);
    bus.we   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.dout;
  endtask

  function automatic logic [31:0] irq_w();
    return {31'h0, bus.irq};
  endfunction

  // One randomized run: model predicts COUNT, CTRL and irq on every cycle
  task automatic trial(input int p, input logic [1:0] mode, input logic im);
    logic [31:0] d;
    bit          per;
    logic        en_exp;
    per = (mode == MODE_PERIODIC);
    rst();
    wr(ADDR_PRESET, 32'(p));
    wr(ADDR_CTRL, {28'h0, im, mode, 1'b1});
    for (int k = 0; k < 2 * (p + 3) + 3; k++) begin
      en_exp = per || (k < p + 4);
      rd(ADDR_COUNT, d);
      chk("rnd_count", d, exp_count(p, k, per));
      rd(ADDR_CTRL, d);
      chk("rnd_ctrl", d, {28'h0, im, mode, en_exp});
      chk("rnd_irq", irq_w(), {31'h0, exp_flag(p, k, per) & im});
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    int          p;
    logic [1:0]  m;
    logic        im;

    bus.addr = ADDR_CTRL;
    bus.we   = 1'b0;
    bus.din  = 32'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state of all four offsets, irq quiet
    rst();
    rd(ADDR_CTRL, d);   chk("rst_ctrl", d, 32'h0);
    rd(ADDR_PRESET, d); chk("rst_preset", d, TB_PRESET_RST);
    rd(ADDR_COUNT, d);  chk("rst_count", d, 32'h0);
    rd(2'd3, d);        chk("rst_addr3", d, 32'h0);
    for (int i = 0; i < 20; i++) begin
      chk("rst_irq_quiet", irq_w(), 32'h0);
      tick();
    end

    // One-shot, P=5: irq from E0+8, held, CTRL shows En cleared, ack by CTRL write
    wr(ADDR_PRESET, 32'd5);
    wr(ADDR_CTRL, 32'h9);
    for (int k = 0; k < 28; k++) begin
      chk("oneshot_irq", irq_w(), {31'h0, k >= 8});
      tick();
    end
    rd(ADDR_CTRL, d); chk("oneshot_ctrl_after", d, 32'h8);
    wr(ADDR_CTRL, 32'h0);
    chk("oneshot_ack_irq", irq_w(), 32'h0);
    tick();
    chk("oneshot_ack_irq_hold", irq_w(), 32'h0);

    // Periodic, P=3: 1-cycle pulse every 6 cycles, then disable mid-count freezes COUNT
    rst();
    wr(ADDR_PRESET, 32'd3);
    wr(ADDR_CTRL, 32'hB);
    for (int k = 0; k < 26; k++) begin
      chk("periodic_irq", irq_w(), {31'h0, exp_flag(3, k, 1'b1)});
      tick();
    end
    wr(ADDR_CTRL, 32'hA);
    for (int i = 0; i < 10; i++) begin
      rd(ADDR_COUNT, d);
      chk("periodic_freeze_count", d, exp_count(3, 27, 1'b1));
      chk("periodic_stopped_irq", irq_w(), 32'h0);
      tick();
    end

    // Masked one-shot, P=2: irq hidden, COUNT at 0, ack keeps irq low after unmasking
    rst();
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h1);
    for (int k = 0; k < 15; k++) begin
      chk("mask_irq", irq_w(), 32'h0);
      tick();
    end
    rd(ADDR_COUNT, d); chk("mask_count", d, 32'h0);
    wr(ADDR_CTRL, 32'h8);
    for (int i = 0; i < 4; i++) begin
      chk("mask_ack_irq", irq_w(), 32'h0);
      tick();
    end

    // PRESET=0 one-shot: irq at E0+3
    rst();
    wr(ADDR_PRESET, 32'd0);
    wr(ADDR_CTRL, 32'h9);
    for (int k = 0; k < 7; k++) begin
      chk("p0_irq", irq_w(), {31'h0, k >= 3});
      tick();
    end

    // PRESET write during CNT: current period unaffected, next period uses 100
    rst();
    wr(ADDR_PRESET, 32'd4);
    wr(ADDR_CTRL, 32'hB);
    tick(); tick(); tick();
    wr(ADDR_PRESET, 32'd100);
    for (int k = 4; k < 13; k++) begin
      rd(ADDR_COUNT, d);
      if (k <= 8) chk("preset_mid_count", d, exp_count(4, k, 1'b1));
      else        chk("preset_next_count", d, 32'(100 - (k - 9)));
      chk("preset_mid_irq", irq_w(), {31'h0, k == 7});
      tick();
    end

    // CTRL write in the INT cycle beats the self-disable and restarts the timer
    rst();
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h9);
    for (int k = 0; k < 5; k++) tick();
    chk("int_wr_irq_before", irq_w(), 32'h1);
    wr(ADDR_CTRL, 32'hB);
    rd(ADDR_CTRL, d); chk("int_wr_ctrl", d, 32'hB);
    for (int k = 0; k < 7; k++) begin
      chk("int_wr_irq", irq_w(), {31'h0, exp_flag(2, k, 1'b1)});
      tick();
    end

    // Ignored writes: COUNT, offset 3 and CTRL upper bits
    rst();
    wr(ADDR_COUNT, 32'hDEAD_BEEF);
    rd(ADDR_COUNT, d);  chk("ro_count", d, 32'h0);
    wr(2'd3, 32'hCAFE_F00D);
    rd(2'd3, d);        chk("ro_addr3", d, 32'h0);
    rd(ADDR_PRESET, d); chk("ro_preset_kept", d, TB_PRESET_RST);
    rd(ADDR_CTRL, d);   chk("ro_ctrl_kept", d, 32'h0);
    wr(ADDR_CTRL, 32'hABCD_EF08);
    rd(ADDR_CTRL, d);   chk("ctrl_upper_ignored", d, 32'h8);

    // Reset while counting with COUNT=7, then a fresh one-shot run
    rst();
    wr(ADDR_PRESET, 32'd10);
    wr(ADDR_CTRL, 32'h9);
    for (int k = 0; k < 5; k++) tick();
    rd(ADDR_COUNT, d); chk("midrst_count_before", d, 32'd7);
    rst();
    rd(ADDR_COUNT, d);  chk("midrst_count", d, 32'h0);
    rd(ADDR_CTRL, d);   chk("midrst_ctrl", d, 32'h0);
    rd(ADDR_PRESET, d); chk("midrst_preset", d, TB_PRESET_RST);
    chk("midrst_irq", irq_w(), 32'h0);
    wr(ADDR_PRESET, 32'd5);
    wr(ADDR_CTRL, 32'h9);
    for (int k = 0; k < 11; k++) begin
      chk("midrst_rerun_irq", irq_w(), {31'h0, k >= 8});
      tick();
    end

    // Randomized runs over preset, all four mode codes and the mask bit
    for (int t = 0; t < 16; t++) begin
      p  = int'($urandom_range(0, 9));
      m  = (t < 4) ? MODE_ONESHOT : 2'($urandom_range(0, 3));
      im = 1'($urandom_range(0, 1));
      trial(p, m, im);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_tc.md
Name: timer_tc

Overview:
- Programmable countdown timer that raises one hardware interrupt line into the CP0 HWInt[15:10] vector (wired to HWInt[10]).
- Sits on the system bridge as a memory-mapped device; the CPU writes and reads it via sw/lw in the M stage.
- Supports one-shot (mode 0) and periodic (mode 1) operation.
- The interrupt is maskable at the device (CTRL.IM) in addition to CP0's SR.IM/IE.

Parameters:
- PRESET_RST, 32'h0: reset value of the PRESET register.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clears all state on the posedge where it is high.
- addr  input  2  word offset within the device (byte address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- we  input  1  write strobe for the selected register, sampled at posedge.
- din  input  32  write data.
- dout  output  32  combinational read data for addr.
- irq  output  1  interrupt request to CP0 HWInt[10].

Behaviour:
- Registers:
  - CTRL[3:0]: bit0 En, bits[2:1] Mode, bit3 IM. Bits [31:4] read 0; writes to them are ignored.
  - PRESET[31:0]: read/write.
  - COUNT[31:0]: read-only; writes are ignored.
  - addr 3: reads 32'h0; writes are ignored.
- Reset: CTRL=0, PRESET=PRESET_RST, COUNT=0, state=IDLE, irq_flag=0, so irq=0.
- irq = irq_flag & CTRL.IM, purely combinational. Clearing IM hides irq but keeps irq_flag.
- FSM states are IDLE, LOAD, CNT, INT; one transition per posedge.
  - IDLE: if En=1, go to LOAD; else stay.
  - LOAD: COUNT<=PRESET, then go to CNT.
  - CNT, checked in priority order:
    - If En=0, go to IDLE; COUNT holds its value.
    - Else if COUNT==0, set irq_flag<=1 and go to INT.
    - Else COUNT<=COUNT-1.
  - INT, mode 0: En<=0 and go to IDLE. irq_flag stays 1 until a CTRL write or reset.
  - INT, mode 1: irq_flag<=0. Go to LOAD if En=1, else go to IDLE.
  - Mode 2 and mode 3 are reserved and behave as mode 0.
- Latency: with a CTRL write of En=1 at edge E0 and PRESET=P, irq_flag rises at edge E0+P+3.
  - Mode 1 period is P+3 cycles.
  - Mode 1 irq is a 1-cycle pulse.
- Write rules:
  - A CTRL write always clears irq_flag; this is the mode-0 acknowledge.
  - A CTRL write in the same cycle as the INT-state En<=0: the written value wins.
  - A PRESET write during CNT does not reload COUNT; it takes effect at the next LOAD.
  - A PRESET write in the same cycle as LOAD: COUNT gets the old PRESET.
- Arithmetic: COUNT decrements modulo 2^32 but never underflows, since 0 is checked first. PRESET=0 gives irq at E0+3.
- Reset mid-count: everything returns to its reset value the same edge, and irq drops the next cycle.

Decomposition:
- Shared package (timer_pkg) holds:
  - addr offsets ADDR_CTRL/ADDR_PRESET/ADDR_COUNT;
  - CTRL bit indices EN_BIT, MODE_LO/MODE_HI, IM_BIT;
  - mode codes MODE_ONESHOT=2'b00, MODE_PERIODIC=2'b01;
  - state encodings S_IDLE/S_LOAD/S_CNT/S_INT (2-bit).
- There is no natural sub-module: register file, FSM and counter are tightly coupled in one module.

Test Plan:
- Reset, then read all four addresses: CTRL=0, PRESET=PRESET_RST, COUNT=0, addr3=0. irq stays 0 for 20 cycles.
- One-shot: write PRESET=5, then CTRL=4'b1001 at E0. irq=1 exactly from E0+8, CTRL reads 4'b1000, and irq stays high 20 cycles. Writing CTRL=0 drops irq the next cycle.
- Periodic: PRESET=3, CTRL=4'b1011. irq pulses 1 cycle wide every 6 cycles for 4 periods. Writing En=0 mid-count freezes COUNT at its current value and stops the pulses.
- Mask: one-shot with IM=0 and PRESET=2. irq stays 0 and COUNT reads 0. Writing CTRL=4'b1000 then clears irq_flag, so irq remains 0, which confirms the ack-on-write rule.
- Edge cases:
  - PRESET=0 one-shot gives irq at E0+3.
  - A PRESET write of 100 during CNT leaves the current countdown intact and is used on the next period.
  - Writes to COUNT, to addr 3 and to CTRL[31:4] have no effect.
- Reset asserted while in CNT with COUNT=7 gives state IDLE, COUNT=0, CTRL=0 and irq=0 after that edge. A new run after reset behaves as in the one-shot scenario.
